ad7476a_sample_scheduler: RTL

Shares one `ad7476a_interface` instance among `NUM_CLIENTS` independent requesters. It latches their conversion requests, grants them round-robin, and issues one ADC conversion per grant. It returns each 12-bit result tagged with the client index that asked for it. It sits between the application logic and the ADC interface; it drives that block's `request_i` and taps its `data_o`, `data_valid_o` and `cs_n_o`.

---
 rtl/ad7476a_sample_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ad7476a_sample_scheduler.sv
// ad7476a_sample_scheduler
//   Shares one AD7476A interface block among NUM_CLIENTS requesters. Requests
//   are latched into a pending mask, granted round-robin, and each grant runs
//   exactly one ADC conversion. Results come back tagged with the client index.
//
// Parameters
//   NUM_CLIENTS     number of requesters (2..16)
//   TIMEOUT_CYCLES  watchdog limit in clk_i cycles (timeout build only)
//   CLIENT_W        derived client index width
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i              one-cycle request pulse per client
//   pending_o          latched, not-yet-granted requests
//   busy_o             high whenever the FSM is not IDLE
//   sample_valid_o     one-cycle result strobe
//   sample_data_o      12-bit result
//   sample_client_o    client owning the result (or the abandoned request)
//   timeout_o          one-cycle strobe when a conversion is abandoned
//   adc_request_o      to ADC request_i
//   adc_cs_n_i         from ADC cs_n_o
//   adc_data_i         from ADC data_o
//   adc_data_valid_i   from ADC data_valid_o
//
// Build option
//   AD7476A_SCHED_TIMEOUT_EN  adds a watchdog over ISSUE/BUSY; when undefined
//                             timeout_o is tied low and the FSM waits forever.

module ad7476a_sample_scheduler #(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CLIENT_W      = $clog2(NUM_CLIENTS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_CLIENTS-1:0] req_i,
  output logic [NUM_CLIENTS-1:0] pending_o,
  output logic                   busy_o,
  output logic                   sample_valid_o,
  output logic [11:0]            sample_data_o,
  output logic [CLIENT_W-1:0]    sample_client_o,
  output logic                   timeout_o,
  output logic                   adc_request_o,
  input  logic                   adc_cs_n_i,
  input  logic [11:0]            adc_data_i,
  input  logic                   adc_data_valid_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DELIVER} state_t;

  state_t                 state_reg;
  logic [NUM_CLIENTS-1:0] pending_reg;
  logic [NUM_CLIENTS-1:0] pending_next;
  logic [NUM_CLIENTS-1:0] grant_clear;
  logic [CLIENT_W-1:0]    rr_ptr_reg;
  logic [CLIENT_W-1:0]    cur_client_reg;
  logic [CLIENT_W-1:0]    sample_client_reg;
  logic [11:0]            sample_data_reg;
  logic [CLIENT_W-1:0]    grant_idx;
  logic [CLIENT_W-1:0]    rr_ptr_next;
  logic                   grant_found;
  logic                   timeout_hit;

  // Round-robin pick: lowest pending index at or above rr_ptr, else lowest
  // pending index overall. Scanning downward lets the lowest match win.
  always_comb begin
    logic                found_hi;
    logic [CLIENT_W-1:0] idx_hi;
    logic [CLIENT_W-1:0] idx_any;
    found_hi    = 1'b0;
    grant_found = 1'b0;
    idx_hi      = '0;
    idx_any     = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        grant_found = 1'b1;
        idx_any     = CLIENT_W'(i);
        if (CLIENT_W'(i) >= rr_ptr_reg) begin
          found_hi = 1'b1;
          idx_hi   = CLIENT_W'(i);
        end
      end
    end
    grant_idx   = found_hi ? idx_hi : idx_any;
    rr_ptr_next = (grant_idx == CLIENT_W'(NUM_CLIENTS - 1)) ? '0 : grant_idx + CLIENT_W'(1);
    grant_clear = '0;
    if (state_reg == IDLE && grant_found) begin
      grant_clear[grant_idx] = 1'b1;
    end
  end

  // A new request on the bit being granted survives the clear (set wins).
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_pending
    assign pending_next[gi] = req_i[gi] | (pending_reg[gi] & ~grant_clear[gi]);
  end

`ifdef AD7476A_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            timeout_reg;

  // Counter is held at zero in IDLE, so it starts from zero on ISSUE entry;
  // the abandon happens once the FSM has spent TIMEOUT_CYCLES cycles waiting.
  assign timeout_hit = (state_reg == ISSUE || state_reg == BUSY) &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_hit;
      if (state_reg == ISSUE || state_reg == BUSY) begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

  assign timeout_o = timeout_reg;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg         <= IDLE;
      pending_reg       <= '0;
      rr_ptr_reg        <= '0;
      cur_client_reg    <= '0;
      sample_client_reg <= '0;
      sample_data_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            cur_client_reg <= grant_idx;
            rr_ptr_reg     <= rr_ptr_next;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          // Leaving ISSUE as soon as CS is seen low drops the request line,
          // so the ADC block runs a single conversion.
          if (timeout_hit) begin
            sample_client_reg <= cur_client_reg;
            state_reg         <= IDLE;
          end else if (!adc_cs_n_i) begin
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (timeout_hit) begin
            sample_client_reg <= cur_client_reg;
            state_reg         <= IDLE;
          end else if (adc_data_valid_i) begin
            sample_data_reg   <= adc_data_i;
            sample_client_reg <= cur_client_reg;
            state_reg         <= DELIVER;
          end
        end
        DELIVER: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Strobes and status come from the state register only.
  assign busy_o          = (state_reg != IDLE);
  assign adc_request_o   = (state_reg == ISSUE);
  assign sample_valid_o  = (state_reg == DELIVER);
  assign pending_o       = pending_reg;
  assign sample_data_o   = sample_data_reg;
  assign sample_client_o = sample_client_reg;

endmodule
